// File: rtl/ifu_fetch.sv
// Instruction fetch: holds the PC, issues one imem read at a time and hands {inst, pc} to decode.
// Latency: inst_valid the cycle after rsp_valid; next request the cycle after decode accepts.
module ifu_fetch #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter int          PC_STEP  = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        halt,
   output logic        halted
);

   typedef enum logic [1:0] {REQ, WAIT, HOLD, HALT} state_t;

   state_t      state, state_nxt;
   logic [31:0] pc, pc_nxt;
   logic        kill, kill_nxt;
   logic [31:0] inst_q, inst_pc_q;
   logic        latch;
   logic [31:0] target;

   assign target = {redirect_pc[31:2], 2'b00};

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= REQ;
         pc        <= RESET_PC;
         kill      <= 1'b0;
         inst_q    <= '0;
         inst_pc_q <= '0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         kill  <= kill_nxt;
         if (latch) begin
            inst_q    <= imem_rsp_data;
            inst_pc_q <= pc;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      kill_nxt  = kill;
      latch     = 1'b0;
      case (state)
         REQ: begin
            if (redirect_valid) pc_nxt = target;
            if (imem_req_ready) begin
               state_nxt = WAIT;
               // The word already in flight belongs to the old path.
               if (redirect_valid) kill_nxt = 1'b1;
            end
         end
         WAIT: begin
            if (redirect_valid) begin
               pc_nxt   = target;
               kill_nxt = 1'b1;
            end
            if (imem_rsp_valid) begin
               if (kill || redirect_valid) begin
                  kill_nxt  = 1'b0;
                  state_nxt = REQ;
               end else begin
                  latch     = 1'b1;
                  state_nxt = HOLD;
               end
            end
         end
         HOLD: begin
            if (redirect_valid) begin
               pc_nxt    = target;
               state_nxt = REQ;
            end else if (inst_ready && halt) begin
               state_nxt = HALT;
            end else if (inst_ready) begin
               pc_nxt    = pc + 32'(PC_STEP);
               state_nxt = REQ;
            end
         end
         HALT: state_nxt = HALT;
         default: state_nxt = REQ;
      endcase
   end

   // Outputs are held at zero for as long as reset is asserted.
   assign imem_req_valid = !rst && (state == REQ);
   assign imem_req_addr  = rst ? 32'h0 : pc;
   assign inst_valid     = !rst && (state == HOLD);
   assign inst           = rst ? 32'h0 : inst_q;
   assign inst_pc        = rst ? 32'h0 : inst_pc_q;
   assign halted         = !rst && (state == HALT);

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: inputs change and outputs are sampled 1ns after each rising edge.
module tb_ifu_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = 32'h0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        halt = 1'b0;
   logic        halted;

   int tests = 0;
   int fails = 0;

   ifu_fetch dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt           (halt),
      .halted         (halted)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // From REQ at address a: handshake, return data d, end in HOLD with d offered.
   task automatic issue(input string tag, input logic [31:0] a, input logic [31:0] d);
      chk({tag, "_req_vld"}, 32'(imem_req_valid), 32'd1);
      chk({tag, "_req_addr"}, imem_req_addr, a);
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      chk({tag, "_wait_req_vld"}, 32'(imem_req_valid), 32'd0);
      chk({tag, "_wait_inst_vld"}, 32'(inst_valid), 32'd0);
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = d;
      tick();
      imem_rsp_valid = 1'b0;
      chk({tag, "_inst_vld"}, 32'(inst_valid), 32'd1);
      chk({tag, "_inst"}, inst, d);
      chk({tag, "_inst_pc"}, inst_pc, a);
   endtask

   task automatic accept();
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
   endtask

   initial begin
      logic [31:0] words [4];
      logic [31:0] held;
      int          leak;
      words[0] = 32'h0000_0013;
      words[1] = 32'h0010_0093;
      words[2] = 32'h0020_0113;
      words[3] = 32'h0030_0193;

      // Reset: all outputs zero.
      tick();
      tick();
      chk("rst_req_vld", 32'(imem_req_valid), 32'd0);
      chk("rst_req_addr", imem_req_addr, 32'h0);
      chk("rst_inst_vld", 32'(inst_valid), 32'd0);
      chk("rst_inst", inst, 32'h0);
      chk("rst_inst_pc", inst_pc, 32'h0);
      chk("rst_halted", 32'(halted), 32'd0);
      rst = 1'b0;
      #1;

      // Sequential fetch I0..I3.
      for (int i = 0; i < 4; i++) begin
         issue("seq", 32'h8000_0000 + 32'(4 * i), words[i]);
         accept();
      end

      // Decode stall for 5 cycles in HOLD.
      issue("stall", 32'h8000_0010, 32'hDEAD_BEEF);
      held = inst;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stall_inst", inst, 32'hDEAD_BEEF);
         chk("stall_inst_pc", inst_pc, 32'h8000_0010);
         chk("stall_req_vld", 32'(imem_req_valid), 32'd0);
         chk("stall_inst_vld", 32'(inst_valid), 32'd1);
      end
      accept();
      chk("resume_req_vld", 32'(imem_req_valid), 32'd1);
      chk("resume_addr", imem_req_addr, 32'h8000_0014);

      // Redirect while waiting: the response is discarded.
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0103;
      tick();
      redirect_valid = 1'b0;
      chk("wredir_inst_vld0", 32'(inst_valid), 32'd0);
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h1111_1111;
      tick();
      imem_rsp_valid = 1'b0;
      chk("wredir_inst_vld", 32'(inst_valid), 32'd0);
      chk("wredir_req_vld", 32'(imem_req_valid), 32'd1);
      chk("wredir_addr", imem_req_addr, 32'h8000_0100);

      // Redirect and accept in the same HOLD cycle: redirect wins.
      issue("hredir", 32'h8000_0100, 32'h2222_2222);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0200;
      accept();
      redirect_valid = 1'b0;
      chk("hredir_inst_vld", 32'(inst_valid), 32'd0);
      chk("hredir_req_vld", 32'(imem_req_valid), 32'd1);
      chk("hredir_addr", imem_req_addr, 32'h8000_0200);

      // ebreak accepted with halt: fetch stops until reset.
      issue("ebrk", 32'h8000_0200, 32'h0010_0073);
      halt = 1'b1;
      accept();
      halt = 1'b0;
      chk("halt_halted", 32'(halted), 32'd1);
      chk("halt_req_vld", 32'(imem_req_valid), 32'd0);
      chk("halt_inst_vld", 32'(inst_valid), 32'd0);
      leak = 0;
      for (int i = 0; i < 20; i++) begin
         redirect_valid = (i % 2 == 0);
         redirect_pc    = 32'h8000_0300;
         imem_rsp_valid = (i % 3 == 0);
         imem_req_ready = 1'b1;
         tick();
         if (imem_req_valid || inst_valid || !halted) leak++;
      end
      redirect_valid = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_req_ready = 1'b0;
      chk("halt_leak_cycles", 32'(leak), 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("post_halt_halted", 32'(halted), 32'd0);
      chk("post_halt_addr", imem_req_addr, 32'h8000_0000);

      // Redirect in REQ without handshake, then wrap past the top of memory.
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFE;
      tick();
      redirect_valid = 1'b0;
      issue("wrap", 32'hFFFF_FFFC, 32'h3333_3333);
      accept();
      chk("wrap_req_vld", 32'(imem_req_valid), 32'd1);
      chk("wrap_addr", imem_req_addr, 32'h0000_0000);

      // Redirect together with the request handshake: in-flight word killed.
      imem_req_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0040;
      tick();
      imem_req_ready = 1'b0;
      redirect_valid = 1'b0;
      chk("rqredir_req_vld", 32'(imem_req_valid), 32'd0);
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h4444_4444;
      tick();
      imem_rsp_valid = 1'b0;
      chk("rqredir_inst_vld", 32'(inst_valid), 32'd0);
      chk("rqredir_addr", imem_req_addr, 32'h8000_0040);

      // Reset in WAIT, late response afterwards is ignored.
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h5555_5555;
      tick();
      imem_rsp_valid = 1'b0;
      chk("late_inst_vld", 32'(inst_valid), 32'd0);
      chk("late_req_vld", 32'(imem_req_valid), 32'd1);
      chk("late_addr", imem_req_addr, 32'h8000_0000);
      chk("late_held_unused", held, 32'hDEAD_BEEF);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit; the producer side of the 32-bit instruction word that the decode stage consumes.
- Holds the PC, issues one read at a time to instruction memory over a valid/ready request and valid-only response interface, and presents {inst, pc} to decode over valid/ready.
- Handles PC redirects from execute and stops permanently after decode reports an ebreak.

Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  32  fetch address; equals the current PC.
- imem_rsp_valid  in  1  read data valid; single-cycle pulse.
- imem_rsp_data  in  32  instruction word.
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode accepts instruction.
- inst  out  32  instruction word to decode.
- inst_pc  out  32  PC of inst.
- redirect_valid  in  1  branch/jump redirect.
- redirect_pc  in  32  redirect target; bits [1:0] forced to 0.
- halt  in  1  decode flags the currently offered inst as ebreak (is_ebreak).
- halted  out  1  fetch stopped.

Behaviour:
- Reset: while rst=1, all outputs are 0, pc<=RESET_PC, kill<=0, state<=REQ. The first request is issued in the first cycle after rst falls.
- Reset mid-transaction: rst aborts everything. Any memory response arriving later with no outstanding request is ignored.
- States: REQ, WAIT, HOLD, HALT. At most one outstanding request.
- REQ:
  - imem_req_valid=1, imem_req_addr=pc.
  - On imem_req_valid & imem_req_ready -> WAIT.
  - If redirect_valid in the same cycle: pc<=target. If the handshake also occurred, set kill=1 (the in-flight word is stale) and go WAIT. Otherwise stay in REQ and request the target next cycle.
- WAIT:
  - imem_req_valid=0.
  - redirect_valid: pc<=target, kill<=1.
  - On imem_rsp_valid:
    - If kill (or redirect_valid in the same cycle): discard data, kill<=0, -> REQ.
    - Otherwise latch inst<=data, inst_pc<=pc, -> HOLD.
  - Responses are accepted unconditionally; there is no rsp_ready.
- HOLD:
  - inst_valid=1. inst and inst_pc are stable until the handshake.
  - Redirect has priority over inst_ready: drop the inst (inst_valid=0 next cycle), pc<=target, -> REQ.
  - Else on inst_ready & halt: -> HALT; pc is not updated.
  - Else on inst_ready: pc<=pc+PC_STEP, -> REQ.
- Latency: request issued the cycle after acceptance by decode. Earliest inst_valid is the cycle after rsp_valid.
- HALT:
  - halted=1; all valids 0.
  - redirect_valid and responses are ignored.
  - Only rst exits.
- Arithmetic: pc+PC_STEP is mod 2^32. 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.
- halt is sampled only on the HOLD handshake cycle. halt outside HOLD is ignored.

Test Plan:
- Reset, memory always ready, 1-cycle response with words I0..I3 -> request addresses 8000_0000, 8000_0004, 8000_0008, 8000_000C in order; decode sees each word with the matching inst_pc.
- Hold inst_ready=0 for 5 cycles in HOLD -> inst and inst_pc stable, imem_req_valid=0 throughout, no new request; fetch resumes the cycle after inst_ready=1.
- Redirect to 8000_0103 while in WAIT, then the response arrives -> response discarded, inst_valid never rises for it, next request address is 8000_0100.
- Redirect and inst_ready in the same HOLD cycle -> inst dropped, pc=target, no pc+4.
- Decode accepts 0010_0073 with halt=1 -> halted=1 the next cycle; no further requests for 20 cycles even with redirect_valid pulses; rst -> refetch from 8000_0000.
- Redirect to FFFF_FFFC, accept -> next request address 0000_0000. Reset asserted in WAIT, late rsp_valid afterwards -> ignored, first request after reset is to RESET_PC.
